// File: rtl/unidade_controle.sv
// Multicycle control unit with a 4x8 register bank driving the 8-bit ALU; 4 cycles per instruction.
// enable=0 stalls every register in place (the only backpressure); HALT is terminal until reset.
module unidade_controle #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  output logic [7:0]      ula_a,
  output logic [7:0]      ula_b,
  output logic [2:0]      ula_op,
  input  logic [7:0]      ula_resultado,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_dado,
  output logic            halted,
  output logic            illegal
);

  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LOAD   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_NEG = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t          state, state_next;
  instr_t          ir;
  logic [PC_W-1:0] pc;
  logic [7:0]      regs [4];

  logic            ir_load;
  logic            ops_load;
  logic            exec_en;

  logic [7:0]      dec_a;
  logic [7:0]      dec_b;
  logic [2:0]      dec_op;
  logic            wr_en;
  logic            is_illegal;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] imm_pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (state != S_HALT && enable) begin
      case (state)
        S_FETCH:  state_next = S_LOAD;
        S_LOAD:   state_next = S_DECODE;
        S_DECODE: state_next = S_EXEC;
        S_EXEC:   state_next = (ir.opcode == OP_HLT) ? S_HALT : S_FETCH;
        default:  state_next = S_HALT;
      endcase
    end
  end

  // Per-state strobes
  always_comb begin
    ir_load  = 1'b0;
    ops_load = 1'b0;
    exec_en  = 1'b0;
    if (enable) begin
      case (state)
        S_LOAD:   ir_load  = 1'b1;
        S_DECODE: ops_load = 1'b1;
        S_EXEC:   exec_en  = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand selection from the latched instruction
  always_comb begin
    dec_a  = 8'h00;
    dec_b  = 8'h00;
    dec_op = 3'd0;
    case (ir.opcode)
      OP_MOV: dec_a = regs[ir.rs];
      OP_ADD: begin dec_op = 3'd1; dec_a = regs[ir.rd]; dec_b = regs[ir.rs]; end
      OP_AND: begin dec_op = 3'd2; dec_a = regs[ir.rd]; dec_b = regs[ir.rs]; end
      OP_OR:  begin dec_op = 3'd3; dec_a = regs[ir.rd]; dec_b = regs[ir.rs]; end
      OP_SUB: begin dec_op = 3'd4; dec_a = regs[ir.rd]; dec_b = regs[ir.rs]; end
      OP_NEG: begin dec_op = 3'd5; dec_a = regs[ir.rd]; end
      OP_NOT: begin dec_op = 3'd6; dec_a = regs[ir.rd]; end
      OP_LDI: dec_a = ir.imm;
      default: ;
    endcase
  end

  // Write-back enable, illegal detection and PC update
  always_comb begin
    imm_pc     = PC_W'(ir.imm);
    wr_en      = (ir.opcode >= OP_MOV) && (ir.opcode <= OP_LDI);
    is_illegal = (ir.opcode > OP_JZ) && (ir.opcode < OP_HLT);
    pc_next    = pc + 1'b1;
    case (ir.opcode)
      OP_JMP: pc_next = imm_pc;
      OP_JZ:  if (regs[ir.rd] == 8'h00) pc_next = imm_pc;
      OP_HLT: pc_next = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      ula_a   <= 8'h00;
      ula_b   <= 8'h00;
      ula_op  <= 3'd0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      if (ir_load) begin
        ir <= instr_t'(instr_data);
      end
      if (ops_load) begin
        ula_a  <= dec_a;
        ula_b  <= dec_b;
        ula_op <= dec_op;
      end
      if (exec_en) begin
        pc <= pc_next;
        if (wr_en) begin
          regs[ir.rd] <= ula_resultado;
        end
        if (is_illegal) begin
          illegal <= 1'b1;
        end
        if (ir.opcode == OP_HLT) begin
          halted <= 1'b1;
        end
      end
    end
  end

  assign instr_addr = pc;
  // Reads the stored value, so a same-cycle write shows only after the edge
  assign dbg_dado   = regs[dbg_sel];

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a synchronous ROM and ALU model alongside.
module tb_unidade_controle;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [PC_W-1:0] instr_addr;
  logic [15:0]     instr_data;
  logic [7:0]      ula_a;
  logic [7:0]      ula_b;
  logic [2:0]      ula_op;
  logic [7:0]      ula_resultado;
  logic [1:0]      dbg_sel;
  logic [7:0]      dbg_dado;
  logic            halted;
  logic            illegal;

  logic [15:0] rom [256];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  unidade_controle #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .instr_addr    (instr_addr),
    .instr_data    (instr_data),
    .ula_a         (ula_a),
    .ula_b         (ula_b),
    .ula_op        (ula_op),
    .ula_resultado (ula_resultado),
    .dbg_sel       (dbg_sel),
    .dbg_dado      (dbg_dado),
    .halted        (halted),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= rom[instr_addr];

  always_comb begin
    case (ula_op)
      3'd0:    ula_resultado = ula_a;
      3'd1:    ula_resultado = ula_a + ula_b;
      3'd2:    ula_resultado = ula_a & ula_b;
      3'd3:    ula_resultado = ula_a | ula_b;
      3'd4:    ula_resultado = ula_a - ula_b;
      3'd5:    ula_resultado = 8'h00 - ula_a;
      3'd6:    ula_resultado = ~ula_a;
      default: ula_resultado = 8'h00;
    endcase
  end

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx);
    dbg_sel = idx;
    #1;
    check(tag, {8'h00, dbg_dado});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    enable = 1'b1;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic load_prog_a();
    clear_rom();
    rom[0] = 16'h8005;   // LDI R0,5
    rom[1] = 16'h8403;   // LDI R1,3
    rom[2] = 16'h2100;   // ADD R0,R1
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    dbg_sel = 2'd0;
    clear_rom();

    // Reset state
    reset_dut();
    for (int i = 0; i < 10; i++) push(16'h0000);
    check("rst_pc", {8'h00, instr_addr});
    check("rst_ula_a", {8'h00, ula_a});
    check("rst_ula_b", {8'h00, ula_b});
    check("rst_ula_op", {13'h0, ula_op});
    check("rst_halted", {15'h0, halted});
    check("rst_illegal", {15'h0, illegal});
    check_reg("rst_r0", 2'd0);
    check_reg("rst_r1", 2'd1);
    check_reg("rst_r2", 2'd2);
    check_reg("rst_r3", 2'd3);

    // LDI/LDI/ADD, including old-value-before-edge on dbg read
    load_prog_a();
    reset_dut();
    push(16'h0005); push(16'h0003); push(16'h0001); push(16'h0005);
    push(16'h0008); push(16'h0003); push(16'h0003);
    step(11);
    check("add_exec_a", {8'h00, ula_a});
    check("add_exec_b", {8'h00, ula_b});
    check("add_exec_op", {13'h0, ula_op});
    check_reg("add_r0_before_edge", 2'd0);
    step(1);
    check_reg("add_r0", 2'd0);
    check_reg("add_r1", 2'd1);
    check("add_pc", {8'h00, instr_addr});

    // SUB / NEG / NOT
    clear_rom();
    rom[0] = 16'h8403; rom[1] = 16'h8008; rom[2] = 16'h5400;
    rom[3] = 16'h6000; rom[4] = 16'h7000;
    reset_dut();
    push(16'h00FB); push(16'h0008); push(16'h00F8); push(16'h0007); push(16'h0005);
    step(12);
    check_reg("sub_r1", 2'd1);
    check_reg("sub_r0", 2'd0);
    step(4);
    check_reg("neg_r0", 2'd0);
    step(4);
    check_reg("not_r0", 2'd0);
    check("not_pc", {8'h00, instr_addr});

    // JZ taken then not taken
    clear_rom();
    rom[0] = 16'h8800; rom[1] = 16'hA810;
    rom[16] = 16'h8801; rom[17] = 16'hA810;
    reset_dut();
    push(16'h0010); push(16'h0012); push(16'h0001);
    step(8);
    check("jz_taken_pc", {8'h00, instr_addr});
    step(8);
    check("jz_not_taken_pc", {8'h00, instr_addr});
    check_reg("jz_r2", 2'd2);

    // JMP then NOP at top of memory wraps
    clear_rom();
    rom[0] = 16'h9040; rom[64] = 16'h90FF; rom[255] = 16'h0000;
    reset_dut();
    push(16'h0040); push(16'h00FF); push(16'h0000);
    step(4);
    check("jmp_40", {8'h00, instr_addr});
    step(4);
    check("jmp_ff", {8'h00, instr_addr});
    step(4);
    check("pc_wrap", {8'h00, instr_addr});

    // Illegal opcode then HLT
    clear_rom();
    rom[0] = 16'h8C5A; rom[1] = 16'hCC00; rom[2] = 16'hF000;
    reset_dut();
    push(16'h0001); push(16'h005A); push(16'h0000); push(16'h0002); push(16'h0000);
    push(16'h0001); push(16'h0002);
    step(8);
    check("ill_flag", {15'h0, illegal});
    check_reg("ill_r3", 2'd3);
    check_reg("ill_r0", 2'd0);
    check("ill_pc", {8'h00, instr_addr});
    check("ill_halted", {15'h0, halted});
    step(4);
    check("hlt_flag", {15'h0, halted});
    check("hlt_pc", {8'h00, instr_addr});
    for (int i = 0; i < 20; i++) push(16'h0002);
    for (int i = 0; i < 20; i++) begin
      enable = i[0];
      step(1);
      check("hlt_pc_hold", {8'h00, instr_addr});
    end
    enable = 1'b1;
    push(16'h0001); push(16'h0001); push(16'h005A);
    check("hlt_sticky", {15'h0, halted});
    check("ill_sticky", {15'h0, illegal});
    check_reg("hlt_r3", 2'd3);

    // enable=0 for 5 cycles while in DECODE
    load_prog_a();
    reset_dut();
    step(6);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(16'h0005); push(16'h0000); push(16'h0001);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("frz_ula_a", {8'h00, ula_a});
      check("frz_ula_op", {13'h0, ula_op});
      check("frz_pc", {8'h00, instr_addr});
    end
    enable = 1'b1;
    push(16'h0008); push(16'h0003); push(16'h0003);
    step(6);
    check_reg("frz_r0", 2'd0);
    check_reg("frz_r1", 2'd1);
    check("frz_pc_end", {8'h00, instr_addr});

    // Reset asserted during EXEC of ADD
    load_prog_a();
    reset_dut();
    step(11);
    rst_n = 1'b0;
    #1;
    push(16'h0000); push(16'h0000); push(16'h0000); push(16'h0000);
    check_reg("mid_rst_r0", 2'd0);
    check_reg("mid_rst_r1", 2'd1);
    check("mid_rst_pc", {8'h00, instr_addr});
    check("mid_rst_ula_a", {8'h00, ula_a});
    step(1);
    rst_n = 1'b1;
    push(16'h0008);
    step(12);
    check_reg("post_rst_r0", 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
